// File: rtl/mem_lsu_pkg.sv
// Shared widths, MIPS32 load/store op codes, LSU state and bus request payload.
package mem_lsu_pkg;

    localparam int unsigned REG_W      = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned ALUOP_W    = 8;
    localparam int unsigned SEL_W      = 4;

    localparam logic [ALUOP_W-1:0] EXE_ADD_OP = 8'b0010_0000;
    localparam logic [ALUOP_W-1:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [ALUOP_W-1:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [ALUOP_W-1:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [ALUOP_W-1:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [ALUOP_W-1:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [ALUOP_W-1:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [ALUOP_W-1:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [ALUOP_W-1:0] EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'b00,
        LSU_REQ  = 2'b01,
        LSU_DONE = 2'b10
    } lsu_state_e;

    typedef struct packed {
        logic             we;
        logic [REG_W-1:0] addr;
        logic [SEL_W-1:0] sel;
        logic [REG_W-1:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/mem_lsu_fmt.sv
// Combinational op decode: alignment, big-endian byte lanes, store replication, load extraction.
module mem_lsu_fmt
    import mem_lsu_pkg::*;
(
    input  logic [ALUOP_W-1:0] aluop,
    input  logic [1:0]         addr_lo,
    input  logic [REG_W-1:0]   rdata,
    input  logic [REG_W-1:0]   rt,
    output logic               is_mem_c,
    output logic               is_store_c,
    output logic               aligned_c,
    output logic [REG_W-1:0]   load_data_c,
    output logic [SEL_W-1:0]   sel_c,
    output logic [REG_W-1:0]   wdata_c
);

    logic [7:0]       byte_v;
    logic [15:0]      half_v;
    logic [SEL_W-1:0] byte_sel;
    logic [SEL_W-1:0] half_sel;

    // Byte 0 of the word sits in the most significant lane.
    always_comb begin
        case (addr_lo)
            2'd0:    byte_v = rdata[31:24];
            2'd1:    byte_v = rdata[23:16];
            2'd2:    byte_v = rdata[15:8];
            default: byte_v = rdata[7:0];
        endcase
        half_v   = addr_lo[1] ? rdata[15:0] : rdata[31:16];
        byte_sel = SEL_W'(4'b1000 >> addr_lo);
        half_sel = addr_lo[1] ? 4'b0011 : 4'b1100;
    end

    always_comb begin
        is_mem_c    = 1'b0;
        is_store_c  = 1'b0;
        aligned_c   = 1'b1;
        load_data_c = '0;
        sel_c       = '0;
        wdata_c     = rt;
        case (aluop)
            EXE_LB_OP: begin
                is_mem_c    = 1'b1;
                load_data_c = {{24{byte_v[7]}}, byte_v};
                sel_c       = byte_sel;
            end
            EXE_LBU_OP: begin
                is_mem_c    = 1'b1;
                load_data_c = {24'h0, byte_v};
                sel_c       = byte_sel;
            end
            EXE_LH_OP: begin
                is_mem_c    = 1'b1;
                aligned_c   = ~addr_lo[0];
                load_data_c = {{16{half_v[15]}}, half_v};
                sel_c       = half_sel;
            end
            EXE_LHU_OP: begin
                is_mem_c    = 1'b1;
                aligned_c   = ~addr_lo[0];
                load_data_c = {16'h0, half_v};
                sel_c       = half_sel;
            end
            EXE_LW_OP: begin
                is_mem_c    = 1'b1;
                aligned_c   = (addr_lo == 2'b00);
                load_data_c = rdata;
                sel_c       = 4'b1111;
            end
            EXE_SB_OP: begin
                is_mem_c   = 1'b1;
                is_store_c = 1'b1;
                sel_c      = byte_sel;
                wdata_c    = {4{rt[7:0]}};
            end
            EXE_SH_OP: begin
                is_mem_c   = 1'b1;
                is_store_c = 1'b1;
                aligned_c  = ~addr_lo[0];
                sel_c      = half_sel;
                wdata_c    = {2{rt[15:0]}};
            end
            EXE_SW_OP: begin
                is_mem_c   = 1'b1;
                is_store_c = 1'b1;
                aligned_c  = (addr_lo == 2'b00);
                sel_c      = 4'b1111;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM stage load/store unit: runs one req/ack bus access per memory op and stalls until it completes.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_W-1:0]      ex_wdata,
    input  logic [REG_ADDR_W-1:0] ex_wd,
    input  logic                  ex_wreg,
    input  logic [ALUOP_W-1:0]    ex_aluop,
    input  logic [REG_W-1:0]      ex_addr,
    input  logic [REG_W-1:0]      ex_reg2,
    output logic [REG_W-1:0]      mem_wdata,
    output logic [REG_ADDR_W-1:0] mem_wd,
    output logic                  mem_wreg,
    output logic                  stallreq,
    output logic                  misalign,
    output logic                  bus_err,
    output logic                  d_req,
    output logic                  d_we,
    output logic [REG_W-1:0]      d_addr,
    output logic [SEL_W-1:0]      d_sel,
    output logic [REG_W-1:0]      d_wdata,
    input  logic [REG_W-1:0]      d_rdata,
    input  logic                  d_ack
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    lsu_state_e       state_q, state_d;
    bus_req_t         bus_q, bus_d;
    logic             req_q, req_d;
    logic [REG_W-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic             is_mem, is_store, aligned;
    logic [REG_W-1:0] load_data, st_wdata;
    logic [SEL_W-1:0] sel;

    mem_lsu_fmt u_fmt (
        .aluop       (ex_aluop),
        .addr_lo     (ex_addr[1:0]),
        .rdata       (rdata_q),
        .rt          (ex_reg2),
        .is_mem_c    (is_mem),
        .is_store_c  (is_store),
        .aligned_c   (aligned),
        .load_data_c (load_data),
        .sel_c       (sel),
        .wdata_c     (st_wdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LSU_IDLE;
            bus_q   <= '0;
            req_q   <= 1'b0;
            rdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bus_q   <= bus_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next state plus write-back/stall outputs; ex_* stay put while stallreq is high.
    always_comb begin
        state_d   = state_q;
        bus_d     = bus_q;
        req_d     = req_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        mem_wdata = ex_wdata;
        mem_wd    = ex_wd;
        mem_wreg  = ex_wreg;
        stallreq  = 1'b0;
        misalign  = 1'b0;
        bus_err   = 1'b0;
        case (state_q)
            LSU_IDLE: begin
                if (is_mem) begin
                    mem_wreg = 1'b0;
                    if (aligned) begin
                        bus_d.we    = is_store;
                        bus_d.addr  = {ex_addr[31:2], 2'b00};
                        bus_d.sel   = sel;
                        bus_d.wdata = st_wdata;
                        req_d       = 1'b1;
                        cnt_d       = '0;
                        err_d       = 1'b0;
                        stallreq    = 1'b1;
                        state_d     = LSU_REQ;
                    end else begin
                        misalign = 1'b1;
                    end
                end
            end
            LSU_REQ: begin
                stallreq = 1'b1;
                mem_wreg = 1'b0;
                if (d_ack) begin
                    rdata_d = d_rdata;
                    req_d   = 1'b0;
                    state_d = LSU_DONE;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = LSU_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LSU_DONE: begin
                state_d = LSU_IDLE;
                if (err_q) begin
                    mem_wreg = 1'b0;
                    bus_err  = 1'b1;
                end else if (is_store) begin
                    mem_wreg = 1'b0;
                end else begin
                    mem_wdata = load_data;
                end
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    assign d_req   = req_q;
    assign d_we    = bus_q.we;
    assign d_addr  = bus_q.addr;
    assign d_sel   = bus_q.sel;
    assign d_wdata = bus_q.wdata;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: per-cycle comparison against a transaction timeline model.
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ex_wdata, ex_addr, ex_reg2, d_rdata;
    logic [4:0]  ex_wd;
    logic        ex_wreg, d_ack;
    logic [7:0]  ex_aluop;
    logic [31:0] mem_wdata, d_addr, d_wdata;
    logic [4:0]  mem_wd;
    logic        mem_wreg, stallreq, misalign, bus_err, d_req, d_we;
    logic [3:0]  d_sel;

    mem_lsu #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .ex_wdata(ex_wdata), .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_aluop(ex_aluop),
        .ex_addr(ex_addr), .ex_reg2(ex_reg2),
        .mem_wdata(mem_wdata), .mem_wd(mem_wd), .mem_wreg(mem_wreg),
        .stallreq(stallreq), .misalign(misalign), .bus_err(bus_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_sel(d_sel), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Model: expected outputs for the current cycle and the last bus request issued.
    logic        chk_en = 1'b0;
    logic [31:0] e_wdata;
    logic [4:0]  e_wd;
    logic        e_wreg, e_wdata_chk, e_stall, e_mis, e_err;
    logic        b_req = 1'b0, b_we = 1'b0;
    logic [31:0] b_addr = '0, b_wdata = '0;
    logic [3:0]  b_sel = '0;
    bit          spur_ack = 1'b0;

    function automatic int m_size(input logic [7:0] op);
        case (op)
            EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: return 1;
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return 2;
            EXE_LW_OP, EXE_SW_OP:             return 4;
            default:                          return 0;
        endcase
    endfunction

    function automatic bit m_store(input logic [7:0] op);
        return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
    endfunction

    function automatic logic [3:0] m_sel(input int n, input int a);
        int s;
        s = 4 - n - a;
        return 4'(((32'd1 << n) - 32'd1) << s);
    endfunction

    function automatic logic [31:0] m_wdata(input int n, input logic [31:0] rt);
        if (n == 1) return 32'(rt[7:0]) * 32'h0101_0101;
        if (n == 2) return 32'(rt[15:0]) * 32'h0001_0001;
        return rt;
    endfunction

    function automatic logic [31:0] m_load(input logic [7:0] op, input int a, input logic [31:0] rd);
        int n;
        logic [63:0] v, m;
        n = m_size(op);
        m = (64'd1 << (8 * n)) - 64'd1;
        v = (64'(rd) >> (8 * (4 - n - a))) & m;
        if (((op == EXE_LB_OP) || (op == EXE_LH_OP)) && v[8*n-1]) v = v | ~m;
        return v[31:0];
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            if (e_wdata_chk) check("mem_wdata", mem_wdata, e_wdata);
            check("mem_wd",   32'(mem_wd),   32'(e_wd));
            check("mem_wreg", 32'(mem_wreg), 32'(e_wreg));
            check("stallreq", 32'(stallreq), 32'(e_stall));
            check("misalign", 32'(misalign), 32'(e_mis));
            check("bus_err",  32'(bus_err),  32'(e_err));
            check("d_req",    32'(d_req),    32'(b_req));
            check("d_we",     32'(d_we),     32'(b_we));
            check("d_addr",   d_addr,        b_addr);
            check("d_sel",    32'(d_sel),    32'(b_sel));
            check("d_wdata",  d_wdata,       b_wdata);
        end
    end

    int          obs_stall, obs_req;
    logic        obs_mis, obs_we, obs_wreg, obs_err;
    logic [3:0]  obs_sel;
    logic [31:0] obs_dw, obs_wdata;
    logic [4:0]  obs_wd;

    // Record what the DUT showed this cycle, then move to just after the next rising edge.
    task automatic tick();
        @(negedge clk);
        if (stallreq) obs_stall++;
        if (d_req) begin
            obs_req++;
            obs_sel = d_sel;
            obs_dw  = d_wdata;
            obs_we  = d_we;
        end
        if (misalign) obs_mis = 1'b1;
        obs_wdata = mem_wdata;
        obs_wd    = mem_wd;
        obs_wreg  = mem_wreg;
        obs_err   = bus_err;
        @(posedge clk);
        #1;
    endtask

    // Present one EX op and walk its expected timeline; ack_at = REQ cycle of d_ack, 0 = never.
    task automatic op(input logic [7:0] aluop, input logic [31:0] addr, input logic [31:0] rt,
                      input logic [31:0] wdata, input logic [4:0] wd, input logic wreg,
                      input logic [31:0] rdata, input int ack_at);
        int n, a, reqlen;
        n = m_size(aluop);
        a = int'(addr[1:0]);
        obs_stall = 0; obs_req = 0; obs_mis = 1'b0;
        ex_aluop = aluop; ex_addr = addr; ex_reg2 = rt;
        ex_wdata = wdata; ex_wd = wd; ex_wreg = wreg;
        d_ack = spur_ack; d_rdata = $urandom;
        e_wdata = wdata; e_wd = wd; e_wreg = wreg; e_wdata_chk = 1'b1;
        e_stall = 1'b0; e_mis = 1'b0; e_err = 1'b0;
        chk_en = 1'b1;
        if (n == 0) begin
            tick();
            return;
        end
        e_wreg = 1'b0;
        if ((a % n) != 0) begin
            e_mis = 1'b1;
            tick();
            return;
        end
        e_stall = 1'b1;
        tick();
        b_req = 1'b1; b_we = m_store(aluop); b_addr = {addr[31:2], 2'b00};
        b_sel = m_sel(n, a); b_wdata = m_store(aluop) ? m_wdata(n, rt) : rt;
        reqlen = (ack_at == 0) ? int'(TMO) : ack_at;
        for (int k = 1; k <= reqlen; k++) begin
            d_ack   = (k == ack_at);
            d_rdata = (k == ack_at) ? rdata : $urandom;
            tick();
        end
        d_ack = spur_ack; d_rdata = $urandom;
        b_req = 1'b0; e_stall = 1'b0;
        if (ack_at == 0) begin
            e_err = 1'b1; e_wdata_chk = 1'b0;
        end else if (!m_store(aluop)) begin
            e_wdata = m_load(aluop, a, rdata); e_wreg = wreg;
        end
        tick();
    endtask

    typedef struct {
        logic [7:0]  aop;
        logic [31:0] addr;
        logic [31:0] rt;
        logic [31:0] rdata;
        int          ack;
    } vec_t;

    vec_t vecs[$];

    initial begin
        rst = 1'b0;
        ex_aluop = EXE_ADD_OP; ex_addr = '0; ex_reg2 = '0; ex_wdata = '0;
        ex_wd = '0; ex_wreg = 1'b0; d_ack = 1'b0; d_rdata = '0;
        #12;
        check("rst_d_req",    32'(d_req),    32'h0);
        check("rst_d_we",     32'(d_we),     32'h0);
        check("rst_d_addr",   d_addr,        32'h0);
        check("rst_d_sel",    32'(d_sel),    32'h0);
        check("rst_d_wdata",  d_wdata,       32'h0);
        check("rst_stallreq", 32'(stallreq), 32'h0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        op(EXE_ADD_OP, 32'h0, 32'h0, 32'h5, 5'd3, 1'b1, 32'h0, 0);
        check("add_wdata", obs_wdata, 32'h5);
        check("add_wd",    32'(obs_wd), 32'd3);
        check("add_wreg",  32'(obs_wreg), 32'd1);
        check("add_stall", 32'(obs_stall), 32'd0);

        spur_ack = 1'b1;
        op(EXE_LB_OP, 32'h101, 32'h0, 32'h77, 5'd4, 1'b1, 32'h1180_2233, 1);
        check("lb_sel",   32'(obs_sel), 32'h4);
        check("lb_wdata", obs_wdata, 32'hFFFF_FF80);
        check("lb_wreg",  32'(obs_wreg), 32'd1);
        check("lb_stall", 32'(obs_stall), 32'd2);
        op(EXE_LBU_OP, 32'h101, 32'h0, 32'h77, 5'd4, 1'b1, 32'h1180_2233, 1);
        check("lbu_wdata", obs_wdata, 32'h0000_0080);
        spur_ack = 1'b0;

        op(EXE_SH_OP, 32'h202, 32'hABCD_1234, 32'h55, 5'd6, 1'b1, 32'h0, 3);
        check("sh_sel",   32'(obs_sel), 32'h3);
        check("sh_dw",    obs_dw, 32'h1234_1234);
        check("sh_we",    32'(obs_we), 32'd1);
        check("sh_req",   32'(obs_req), 32'd3);
        check("sh_stall", 32'(obs_stall), 32'd4);
        check("sh_wreg",  32'(obs_wreg), 32'd0);

        op(EXE_LW_OP, 32'h103, 32'h0, 32'h66, 5'd2, 1'b1, 32'h0, 1);
        check("misal_flag",  32'(obs_mis), 32'd1);
        check("misal_req",   32'(obs_req), 32'd0);
        check("misal_stall", 32'(obs_stall), 32'd0);
        check("misal_wreg",  32'(obs_wreg), 32'd0);

        op(EXE_LW_OP, 32'h400, 32'h0, 32'h66, 5'd2, 1'b1, 32'h0, 0);
        check("tmo_req",  32'(obs_req), 32'd4);
        check("tmo_err",  32'(obs_err), 32'd1);
        check("tmo_wreg", 32'(obs_wreg), 32'd0);

        vecs.push_back('{EXE_LB_OP,  32'h100, 32'h0,         32'h8112_F37F, 1});
        vecs.push_back('{EXE_LB_OP,  32'h102, 32'h0,         32'h8112_F37F, 2});
        vecs.push_back('{EXE_LBU_OP, 32'h103, 32'h0,         32'h8112_F37F, 1});
        vecs.push_back('{EXE_LH_OP,  32'h102, 32'h0,         32'h1234_8765, 4});
        vecs.push_back('{EXE_LH_OP,  32'h100, 32'h0,         32'h7234_8765, 1});
        vecs.push_back('{EXE_LHU_OP, 32'h100, 32'h0,         32'h9ABC_1234, 2});
        vecs.push_back('{EXE_LW_OP,  32'h200, 32'h0,         32'hCAFE_F00D, 3});
        vecs.push_back('{EXE_SB_OP,  32'h303, 32'h1234_56A5, 32'h0,         1});
        vecs.push_back('{EXE_SB_OP,  32'h300, 32'h1234_5611, 32'h0,         2});
        vecs.push_back('{EXE_SW_OP,  32'h404, 32'hDEAD_BEEF, 32'h0,         1});
        vecs.push_back('{EXE_SH_OP,  32'h201, 32'h1111_2222, 32'h0,         1});
        vecs.push_back('{EXE_LHU_OP, 32'h103, 32'h0,         32'h0,         1});
        vecs.push_back('{EXE_ADD_OP, 32'h104, 32'h0,         32'h0,         1});
        vecs.push_back('{EXE_SW_OP,  32'h40A, 32'h1,         32'h0,         1});
        foreach (vecs[i])
            op(vecs[i].aop, vecs[i].addr, vecs[i].rt, 32'hC0DE_0000 | 32'(i),
               5'(i + 1), 1'(i % 2), vecs[i].rdata, vecs[i].ack);

        // Reset while a load is waiting for ack.
        chk_en = 1'b0;
        ex_aluop = EXE_LW_OP; ex_addr = 32'h600; ex_wdata = 32'h0; ex_wd = 5'd1; ex_wreg = 1'b1;
        d_ack = 1'b0;
        @(negedge clk); @(posedge clk); #1;
        check("rst_pre_req", 32'(d_req), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rst_mid_req",  32'(d_req), 32'd0);
        check("rst_mid_addr", d_addr, 32'h0);
        ex_aluop = EXE_ADD_OP; ex_wdata = 32'h99; ex_wd = 5'd7; ex_wreg = 1'b1;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("rst_rel_stall", 32'(stallreq), 32'd0);
        check("rst_rel_wreg",  32'(mem_wreg), 32'd1);
        check("rst_rel_wdata", mem_wdata, 32'h99);
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_sel = '0; b_wdata = '0;

        op(EXE_ADD_OP, 32'h0, 32'h0, 32'h1234, 5'd9, 1'b0, 32'h0, 0);
        op(EXE_LW_OP, 32'h500, 32'h0, 32'h0, 5'd10, 1'b1, 32'h0BAD_F00D, 2);
        check("post_rst_lw", obs_wdata, 32'h0BAD_F00D);

        @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
